// File: rtl/ibi_scheduler_pkg.sv
// Shared definitions for the target-side IBI scheduler: FSM state encoding,
// status codes and the Hot-Join broadcast address.
package ibi_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_AVAIL = 3'd1,
    ST_REQUEST    = 3'd2,
    ST_XFER       = 3'd3,
    ST_REPORT     = 3'd4
  } ibi_sched_state_e;

  // Per-request completion codes reported on status_o
  localparam logic [1:0] IBI_ST_OK    = 2'b00;
  localparam logic [1:0] IBI_ST_NACK  = 2'b01;
  localparam logic [1:0] IBI_ST_ABORT = 2'b10;

  // Address sent in the header of a Hot-Join request
  localparam logic [6:0] HOT_JOIN_ADDR = 7'h02;

  // Width of the Bus Available timer and its threshold
  localparam int unsigned AVAIL_W = 20;

endpackage

// File: rtl/bus_avail_timer.sv
// Bus Available timer: counts consecutive clk_i cycles with the bus idle
// (SCL and SDA high, no START) while enabled by the scheduler. Any non-idle
// cycle, a START, or the enable dropping clears the count. The count
// saturates at all ones so a very long idle period never wraps to zero.
module bus_avail_timer
  import ibi_scheduler_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               bus_idle_i,
  input  logic               start_det_i,
  input  logic [AVAIL_W-1:0] threshold_i,
  output logic               reached_o
);

  logic [AVAIL_W-1:0] cnt_q, cnt_d;
  logic               run;

  // Counting is only meaningful on an enabled, idle, START-free cycle
  assign run = en_i & bus_idle_i & ~start_det_i;

  // Reached is qualified by the current cycle being idle, so a zero
  // threshold still needs one idle cycle before the header may start
  assign reached_o = run & (cnt_q >= threshold_i);

  // Next count: clear when not running, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q != {AVAIL_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ibi_scheduler.sv
// Target-side In-Band Interrupt scheduler. Takes one IBI request at a time
// from the TTI IBI queue, waits for Bus Available, hands header attempts to
// the flow FSM, retries NACKs up to ibi_retry_num_i, and reports one status
// per request.
//
// Build option: define I3C_IBI_HOT_JOIN_EN to let hj_req_i launch a Hot-Join
// (address 7'h02) while no valid target address is configured.
//
// Request handshake: the queue holds ibi_req_valid_i with stable data until
// the scheduler pulses ibi_req_ready_o; a transfer (pop) happens on the cycle
// where both are high, which is only the single REPORT cycle. Hot-Join runs
// never pulse ready, so the queue is left untouched.
module ibi_scheduler
  import ibi_scheduler_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ibi_enable_i,
  input  logic [2:0]         ibi_retry_num_i,
  input  logic [6:0]         target_ibi_addr_i,
  input  logic               target_ibi_addr_valid_i,
  input  logic [AVAIL_W-1:0] t_bus_available_i,
  input  logic               bus_idle_i,
  input  logic               start_det_i,
  input  logic               abort_i,
  input  logic               ibi_req_valid_i,
  output logic               ibi_req_ready_o,
  output logic               ibi_start_o,
  output logic [6:0]         ibi_addr_o,
  input  logic               arb_lost_i,
  input  logic               ibi_ack_i,
  input  logic               ibi_nack_i,
  input  logic               xfer_done_i,
  output logic               status_valid_o,
  output logic [1:0]         status_o,
  input  logic               hj_req_i,
  output ibi_sched_state_e   dbg_state_o
);

  ibi_sched_state_e state_q, state_d;
  logic [6:0]       addr_q, addr_d;
  logic [2:0]       nack_q, nack_d;
  logic [1:0]       status_q, status_d;
  logic             hj_q, hj_d;
  logic             start_q, ready_q, valid_q;
  logic             avail_reached;

`ifndef I3C_IBI_HOT_JOIN_EN
  logic unused_hj_req;
  assign unused_hj_req = hj_req_i;
`endif

  bus_avail_timer u_bus_avail_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (state_q == ST_WAIT_AVAIL),
    .bus_idle_i  (bus_idle_i),
    .start_det_i (start_det_i),
    .threshold_i (t_bus_available_i),
    .reached_o   (avail_reached)
  );

  // Next-state logic; abort beats arbitration loss beats NACK beats ACK
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    nack_d   = nack_q;
    status_d = status_q;
    hj_d     = hj_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ibi_req_valid_i && ibi_enable_i && target_ibi_addr_valid_i) begin
          state_d = ST_WAIT_AVAIL;
          addr_d  = target_ibi_addr_i;
          nack_d  = '0;
          hj_d    = 1'b0;
        end
`ifdef I3C_IBI_HOT_JOIN_EN
        else if (hj_req_i && !target_ibi_addr_valid_i) begin
          state_d = ST_WAIT_AVAIL;
          addr_d  = HOT_JOIN_ADDR;
          nack_d  = '0;
          hj_d    = 1'b1;
        end
`endif
      end
      ST_WAIT_AVAIL: begin
        if (abort_i || !ibi_enable_i) begin
          state_d  = ST_REPORT;
          status_d = IBI_ST_ABORT;
        end else if (avail_reached) begin
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (abort_i) begin
          state_d  = ST_REPORT;
          status_d = IBI_ST_ABORT;
        end else if (arb_lost_i) begin
          // Losing arbitration is not an attempt: go back and wait again
          state_d = ST_WAIT_AVAIL;
        end else if (ibi_nack_i) begin
          if (nack_q == ibi_retry_num_i) begin
            state_d  = ST_REPORT;
            status_d = IBI_ST_NACK;
          end else begin
            state_d = ST_WAIT_AVAIL;
            nack_d  = nack_q + 1'b1;
          end
        end else if (ibi_ack_i) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (abort_i) begin
          state_d  = ST_REPORT;
          status_d = IBI_ST_ABORT;
        end else if (xfer_done_i) begin
          state_d  = ST_REPORT;
          status_d = IBI_ST_OK;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, attempt bookkeeping and registered outputs decoded from next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      nack_q   <= '0;
      status_q <= IBI_ST_OK;
      hj_q     <= 1'b0;
      start_q  <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      nack_q   <= nack_d;
      status_q <= status_d;
      hj_q     <= hj_d;
      start_q  <= (state_d == ST_REQUEST);
      valid_q  <= (state_d == ST_REPORT);
      ready_q  <= (state_d == ST_REPORT) && !hj_d;
    end
  end

  assign ibi_start_o     = start_q;
  assign ibi_req_ready_o = ready_q;
  assign status_valid_o  = valid_q;
  assign status_o        = status_q;
  assign ibi_addr_o      = addr_q;
  assign dbg_state_o     = state_q;

endmodule
